// File: rtl/pc_stack_seq.sv
// Program-counter sequencer for the fetch stage: increment, jump, relative branch,
// call/return through a LIFO return-address stack, and stall.
module pc_stack_seq #(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input  logic                               i_Clk,
  input  logic                               i_Rst_n,
  input  logic                               i_Stall,
  input  logic [2:0]                         i_Op,
  input  logic [ADDR_W-1:0]                  i_Target,
  input  logic [ADDR_W-1:0]                  i_Offset,
  input  logic                               i_Cond,
  output logic [ADDR_W-1:0]                  o_Addr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   o_Depth,
  output logic                               o_Ovf,
  output logic                               o_Udf
);

  localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);
  localparam logic [DepthW-1:0] DepthMax = DepthW'(STACK_DEPTH);

  localparam logic [2:0] OpInc  = 3'b000;
  localparam logic [2:0] OpJmp  = 3'b001;
  localparam logic [2:0] OpBr   = 3'b010;
  localparam logic [2:0] OpCall = 3'b011;
  localparam logic [2:0] OpRet  = 3'b100;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DepthW-1:0] depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] top_entry;
  logic              stack_full;
  logic              stack_empty;
  logic              push;

  assign pc_inc      = pc_q + ADDR_W'(1);
  assign stack_full  = (depth_q == DepthMax);
  assign stack_empty = (depth_q == '0);

  // Entry at index depth-1, i.e. the most recently pushed return address.
  always_comb begin
    top_entry = '0;
    for (int i = 0; i < int'(STACK_DEPTH); i++) begin
      if (depth_q == DepthW'(i + 1)) begin
        top_entry = stack_q[i];
      end
    end
  end

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    push    = 1'b0;
    if (!i_Stall) begin
      case (i_Op)
        OpInc: pc_d = pc_inc;
        OpJmp: pc_d = i_Target;
        OpBr:  pc_d = i_Cond ? (pc_q + i_Offset) : pc_inc;
        OpCall: begin
          pc_d = i_Target;
          if (stack_full) begin
            ovf_d = 1'b1;
          end else begin
            push    = 1'b1;
            depth_d = depth_q + DepthW'(1);
          end
        end
        OpRet: begin
          if (stack_empty) begin
            pc_d  = pc_inc;
            udf_d = 1'b1;
          end else begin
            pc_d    = top_entry;
            depth_d = depth_q - DepthW'(1);
          end
        end
        default: pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      pc_q    <= RESET_VEC;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Stack contents are don't-care after reset, so no reset term here.
  always_ff @(posedge i_Clk) begin
    for (int i = 0; i < int'(STACK_DEPTH); i++) begin
      if (i_Rst_n && push && (depth_q == DepthW'(i))) begin
        stack_q[i] <= pc_inc;
      end
    end
  end

  assign o_Addr  = pc_q;
  assign o_Depth = depth_q;
  assign o_Ovf   = ovf_q;
  assign o_Udf   = udf_q;

endmodule

// File: tb/tb_pc_stack_seq.sv
// Directed bench for pc_stack_seq with hand-computed expected values.
module tb_pc_stack_seq;

  localparam logic [2:0] OpInc  = 3'b000;
  localparam logic [2:0] OpJmp  = 3'b001;
  localparam logic [2:0] OpBr   = 3'b010;
  localparam logic [2:0] OpCall = 3'b011;
  localparam logic [2:0] OpRet  = 3'b100;

  logic       i_Clk;
  logic       i_Rst_n;
  logic       i_Stall;
  logic [2:0] i_Op;
  logic [7:0] i_Target;
  logic [7:0] i_Offset;
  logic       i_Cond;
  logic [7:0] o_Addr;
  logic [2:0] o_Depth;
  logic       o_Ovf;
  logic       o_Udf;

  int total = 0;
  int bad   = 0;

  pc_stack_seq #(
    .ADDR_W      (8),
    .STACK_DEPTH (4),
    .RESET_VEC   (8'h00)
  ) dut (
    .i_Clk    (i_Clk),
    .i_Rst_n  (i_Rst_n),
    .i_Stall  (i_Stall),
    .i_Op     (i_Op),
    .i_Target (i_Target),
    .i_Offset (i_Offset),
    .i_Cond   (i_Cond),
    .o_Addr   (o_Addr),
    .o_Depth  (o_Depth),
    .o_Ovf    (o_Ovf),
    .o_Udf    (o_Udf)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one operation, clock it, then settle 1 time unit past the edge.
  task automatic step(input logic [2:0] op, input logic [7:0] tgt, input logic [7:0] off,
                      input logic cond, input logic stall, input logic rst_n);
    i_Op     = op;
    i_Target = tgt;
    i_Offset = off;
    i_Cond   = cond;
    i_Stall  = stall;
    i_Rst_n  = rst_n;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] addr, input logic [2:0] depth,
                             input logic ovf, input logic udf);
    check_eq({tag, ".addr"},  16'(o_Addr),  16'(addr));
    check_eq({tag, ".depth"}, 16'(o_Depth), 16'(depth));
    check_eq({tag, ".ovf"},   16'(o_Ovf),   16'(ovf));
    check_eq({tag, ".udf"},   16'(o_Udf),   16'(udf));
  endtask

  initial begin
    i_Rst_n  = 1'b0;
    i_Stall  = 1'b0;
    i_Op     = OpInc;
    i_Target = '0;
    i_Offset = '0;
    i_Cond   = 1'b0;

    // Reset, with a CALL pending to show reset wins.
    step(OpCall, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0);
    step(OpCall, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0);
    check_state("reset", 8'h00, 3'd0, 1'b0, 1'b0);

    step(OpInc, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_state("inc1", 8'h01, 3'd0, 1'b0, 1'b0);
    step(OpInc, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("inc2", 16'(o_Addr), 16'h02);
    step(OpInc, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_state("inc3", 8'h03, 3'd0, 1'b0, 1'b0);

    // Wrap, jump and branch.
    step(OpJmp, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("jmp_fe", 16'(o_Addr), 16'hFE);
    step(OpInc, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("inc_ff", 16'(o_Addr), 16'hFF);
    step(3'b111, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("op7_wrap", 16'(o_Addr), 16'h00);
    step(OpJmp, 8'h40, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("jmp_40", 16'(o_Addr), 16'h40);
    step(OpBr, 8'h00, 8'hFC, 1'b1, 1'b0, 1'b1);
    check_eq("br_back", 16'(o_Addr), 16'h3C);
    step(OpBr, 8'h00, 8'hFC, 1'b0, 1'b0, 1'b1);
    check_eq("br_nt", 16'(o_Addr), 16'h3D);

    // Nested calls.
    step(OpJmp, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1);
    step(OpCall, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1);
    check_state("call1", 8'h80, 3'd1, 1'b0, 1'b0);
    step(OpCall, 8'h90, 8'h00, 1'b0, 1'b0, 1'b1);
    check_state("call2", 8'h90, 3'd2, 1'b0, 1'b0);
    step(OpRet, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_state("ret1", 8'h81, 3'd1, 1'b0, 1'b0);
    step(OpRet, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_state("ret2", 8'h11, 3'd0, 1'b0, 1'b0);

    // Overflow: four pushes of 0x31, 0x51, 0x61, 0x71.
    step(OpJmp, 8'h30, 8'h00, 1'b0, 1'b0, 1'b1);
    step(OpCall, 8'h50, 8'h00, 1'b0, 1'b0, 1'b1);
    step(OpCall, 8'h60, 8'h00, 1'b0, 1'b0, 1'b1);
    step(OpCall, 8'h70, 8'h00, 1'b0, 1'b0, 1'b1);
    step(OpCall, 8'h78, 8'h00, 1'b0, 1'b0, 1'b1);
    check_state("call4", 8'h78, 3'd4, 1'b0, 1'b0);
    step(OpCall, 8'hA0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_state("call_ovf", 8'hA0, 3'd4, 1'b1, 1'b0);
    step(OpRet, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_state("ovf_ret1", 8'h71, 3'd3, 1'b1, 1'b0);
    step(OpRet, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_state("ovf_ret2", 8'h61, 3'd2, 1'b1, 1'b0);
    step(OpRet, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_state("ovf_ret3", 8'h51, 3'd1, 1'b1, 1'b0);
    step(OpRet, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_state("ovf_ret4", 8'h31, 3'd0, 1'b1, 1'b0);

    // Underflow, then reset clears both flags.
    step(OpJmp, 8'h22, 8'h00, 1'b0, 1'b0, 1'b1);
    step(OpRet, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_state("udf", 8'h23, 3'd0, 1'b1, 1'b1);
    step(OpInc, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check_state("rst_clr", 8'h00, 3'd0, 1'b0, 1'b0);

    // Wrapped return address pushed as-is; back-to-back CALL/RET.
    step(OpJmp, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    step(OpCall, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1);
    check_state("call_wrap", 8'h10, 3'd1, 1'b0, 1'b0);
    step(OpRet, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_state("ret_wrap", 8'h00, 3'd0, 1'b0, 1'b0);

    // Stall holds a pending CALL for three edges.
    step(OpJmp, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(OpCall, 8'h70, 8'h00, 1'b0, 1'b1, 1'b1);
      check_state("stall", 8'h05, 3'd0, 1'b0, 1'b0);
    end
    step(OpCall, 8'h70, 8'h00, 1'b0, 1'b0, 1'b1);
    check_state("stall_rel", 8'h70, 3'd1, 1'b0, 1'b0);
    step(OpCall, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("depth2", 16'(o_Depth), 16'd2);

    // Reset beats stall; a following RET underflows.
    step(OpCall, 8'h90, 8'h00, 1'b0, 1'b1, 1'b0);
    check_state("rst_stall", 8'h00, 3'd0, 1'b0, 1'b0);
    step(OpRet, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_state("post_rst_udf", 8'h01, 3'd0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_stack_seq.md
# pc_stack_seq

Parametrised program-counter sequencer for the microcontroller fetch stage. It drives the instruction-memory address bus each cycle and supports:
- increment
- absolute jump
- conditional PC-relative branch
- subroutine call/return through an internal LIFO return-address stack
- pipeline stall

Overflow and underflow of the stack are reported through sticky error flags.

## Interface
Parameters:
- ADDR_W, 8, width of the address bus and PC register (≥ 2)
- STACK_DEPTH, 4, number of return-address entries (≥ 1)
- RESET_VEC, 0, PC value loaded on reset (ADDR_W bits)

Ports:
- i_Clk  in  1  system clock; all state changes on rising edge
- i_Rst_n  in  1  reset, synchronous, active-low
- i_Stall  in  1  1 = hold all state this cycle
- i_Op  in  3  operation: 000 INC, 001 JMP, 010 BR, 011 CALL, 100 RET, 101–111 treated as INC
- i_Target  in  ADDR_W  absolute destination for JMP and CALL
- i_Offset  in  ADDR_W  two's-complement displacement for BR
- i_Cond  in  1  BR taken when 1; BR with i_Cond=0 behaves as INC
- o_Addr  out  ADDR_W  current PC (register output, no combinational path from inputs)
- o_Depth  out  $clog2(STACK_DEPTH+1)  number of valid stack entries
- o_Ovf  out  1  sticky: CALL attempted with stack full
- o_Udf  out  1  sticky: RET attempted with stack empty

## Operation
- Reset (i_Rst_n=0 at a rising edge):
  - o_Addr←RESET_VEC
  - o_Depth←0
  - o_Ovf←0, o_Udf←0
  - stack contents don't-care
  - Reset overrides i_Stall and i_Op.
- Stall (i_Stall=1, not in reset):
  - PC, stack, depth and flags all hold.
  - Stall overrides every i_Op.
- Otherwise, per rising edge:
  - INC: PC←PC+1.
  - JMP: PC←i_Target.
  - BR with i_Cond=1: PC←PC+i_Offset. The sum is ADDR_W bits, modulo 2^ADDR_W, so negative offsets branch backward.
  - BR with i_Cond=0: PC←PC+1.
  - CALL, stack not full:
    - push PC+1 (mod 2^ADDR_W) at index o_Depth
    - o_Depth+1
    - PC←i_Target
  - CALL, stack full (o_Depth=STACK_DEPTH):
    - no push, depth unchanged
    - PC←i_Target
    - o_Ovf←1
  - RET, stack not empty:
    - PC←entry[o_Depth−1]
    - o_Depth−1
  - RET, stack empty:
    - PC←PC+1, depth stays 0
    - o_Udf←1
- The return stack is strictly LIFO.
- o_Ovf and o_Udf clear only on reset.
- Arithmetic: all PC math wraps silently. 2^ADDR_W−1 +1 = 0, and a wrapped return address is pushed as-is.

## Timing
- Single-cycle sequencer: inputs are sampled at edge N, and the new o_Addr, o_Depth and flags are visible after edge N.
- No multi-cycle states; throughput is one operation per cycle.
- A RET immediately after a CALL, on back-to-back edges, returns the address pushed by that CALL. No bypass hazard: the stack write and depth update complete at the CALL edge.
- The flag set by an erroneous CALL/RET is visible after the same edge that performs the operation.
- Reset deasserted at edge N:
  - edge N is the first operational edge
  - o_Addr shows RESET_VEC until after edge N.
- Reset asserted mid-sequence (e.g. depth 3): after the next edge, o_Depth=0, o_Addr=RESET_VEC and both flags are 0. A following RET reports o_Udf.
- i_Stall held for K cycles delays the pending operation by exactly K cycles. The operation present on the first non-stalled edge is the one executed.

## Test plan
Common setup: ADDR_W=8, STACK_DEPTH=4, RESET_VEC=8'h00.
- Reset, then 3 INC edges → o_Addr 0x00→0x01→0x02→0x03; o_Depth=0; flags 0.
- PC=0xFE: 2 INC → 0xFF then 0x00 (wrap). Then JMP i_Target=0x40 → 0x40. Then BR i_Offset=0xFC, i_Cond=1 → 0x3C. Then BR i_Cond=0 → 0x3D.
- Nested calls: at PC=0x10, CALL 0x80 → PC=0x80, depth 1. Then CALL 0x90 → PC=0x90, depth 2. RET → 0x81, depth 1. RET → 0x11, depth 0. Flags stay 0.
- Overflow:
  - 4 CALLs → depth 4, flags 0.
  - 5th CALL 0xA0 → PC=0xA0, depth 4, o_Ovf=1.
  - 4 RETs return the 4 pushed addresses in reverse order; o_Ovf stays 1.
- Underflow: at depth 0 with PC=0x22, RET → PC=0x23, o_Udf=1, depth 0. Then a synchronous reset (i_Rst_n=0 for 1 edge) → PC=0x00, both flags 0.
- Stall: with PC=0x05, i_Op=CALL 0x70 and i_Stall=1 for 3 edges → PC stays 0x05, depth 0. On stall release → PC=0x70, depth 1. i_Rst_n=0 together with i_Stall=1 → reset takes effect.
